// File: rtl/noc_pkg.sv
// Shared NoC helpers: flit address extraction and range-based route decode.
package noc_pkg;

    localparam int unsigned MaxFlitW = 256;
    localparam int unsigned MaxAddrW = 32;

    // Destination address sits in the top AddrWidth bits of the flit.
    function automatic logic [MaxAddrW-1:0] flit_addr(input logic [MaxFlitW-1:0] flit,
                                                      input int unsigned dw,
                                                      input int unsigned aw);
        logic [MaxFlitW-1:0] shifted;
        logic [MaxAddrW-1:0] mask;
        shifted = flit >> (dw - aw);
        mask    = (aw >= MaxAddrW) ? '1 : ((MaxAddrW'(1) << aw) - MaxAddrW'(1));
        return shifted[MaxAddrW-1:0] & mask;
    endfunction

    // Child index owning addr, or num_child (the parent port) when outside the node range.
    function automatic int unsigned route_port(input int unsigned addr, base, span, num_child);
        if ((addr >= base) && (addr < base + num_child * span)) begin
            return (addr - base) / span;
        end
        return num_child;
    endfunction

    // The parent port always takes the index after the last child.
    function automatic int unsigned parent_port(input int unsigned num_child);
        return num_child;
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Per-port input buffer: synchronous FIFO with a registered ready (not-full) flag.
module noc_sync_fifo #(
    parameter int unsigned DataWidth = 36,
    parameter int unsigned Depth     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DataWidth-1:0] push_data_i,
    input  logic                 push_valid_i,
    output logic                 push_ready_o,
    input  logic                 pop_i,
    output logic [DataWidth-1:0] head_data_o,
    output logic                 head_valid_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      wptr_q, rptr_q;
    logic [CntW-1:0]      count_q, count_d;
    logic                 ready_q;
    logic                 push, pop;

    assign push         = push_valid_i && ready_q;
    assign pop          = pop_i && (count_q != '0);
    assign head_data_o  = mem_q[rptr_q];
    assign head_valid_o = (count_q != '0);
    assign push_ready_o = ready_q;

    // Occupancy after this cycle's push/pop; ready is derived from it so it is already registered.
    always_comb begin
        count_d = count_q + CntW'(push) - CntW'(pop);
    end

    // Pointers, occupancy and ready flag; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
            ready_q <= (count_d != CntW'(Depth));
        end
    end

    // Storage needs no reset: stale entries are never visible while count is zero.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= push_data_i;
    end

endmodule

// File: rtl/btree_router_node.sv
// K-ary tree router node: NUM_CHILD child ports plus one parent port, buffered inputs,
// address-range routing and a round-robin arbiter with an output register per output port.
module btree_router_node
    import noc_pkg::*;
#(
    parameter int unsigned DataWidth  = 36,
    parameter int unsigned AddrWidth  = 4,
    parameter int unsigned NUM_CHILD  = 2,
    parameter int unsigned CHILD_BASE = 0,
    parameter int unsigned CHILD_SPAN = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                           i_sclk,
    input  logic                           i_reset,
    input  logic [NUM_CHILD*DataWidth-1:0] i_child_data,
    input  logic [NUM_CHILD-1:0]           i_child_valid,
    output logic [NUM_CHILD-1:0]           o_child_ready,
    output logic [NUM_CHILD*DataWidth-1:0] o_child_data,
    output logic [NUM_CHILD-1:0]           o_child_valid,
    input  logic [NUM_CHILD-1:0]           i_child_ready,
    input  logic [DataWidth-1:0]           i_parent_data,
    input  logic                           i_parent_valid,
    output logic                           o_parent_ready,
    output logic [DataWidth-1:0]           o_parent_data,
    output logic                           o_parent_valid,
    input  logic                           i_parent_ready,
    output logic                           o_misroute
);

    localparam int unsigned P      = NUM_CHILD + 1;
    localparam int unsigned PW     = $clog2(P);
    localparam int unsigned Parent = parent_port(NUM_CHILD);

    typedef logic [DataWidth-1:0] flit_t;

    flit_t          in_data    [P];
    flit_t          head_data  [P];
    logic [P-1:0]   in_valid, in_ready, out_ready, head_valid, pop, load;
    logic [PW-1:0]  dest       [P];
    logic [P-1:0]   req        [P];  // req[o][i]: head of input i wants output o
    logic [PW-1:0]  gnt_idx    [P];
    logic [PW-1:0]  rr_q       [P];
    logic [PW-1:0]  rr_d       [P];
    logic [P-1:0]   out_valid_q, out_valid_d;
    flit_t          out_data_q [P];
    flit_t          out_data_d [P];
    logic           misroute_q, misroute_d;

    // Flatten child and parent ports into uniform per-port arrays.
    for (genvar c = 0; c < NUM_CHILD; c++) begin : g_child_io
        assign in_data[c]                                = i_child_data[c*DataWidth +: DataWidth];
        assign in_valid[c]                               = i_child_valid[c];
        assign out_ready[c]                              = i_child_ready[c];
        assign o_child_ready[c]                          = in_ready[c];
        assign o_child_data[c*DataWidth +: DataWidth]    = out_data_q[c];
        assign o_child_valid[c]                          = out_valid_q[c];
    end

    assign in_data[Parent]   = i_parent_data;
    assign in_valid[Parent]  = i_parent_valid;
    assign out_ready[Parent] = i_parent_ready;
    assign o_parent_ready    = in_ready[Parent];
    assign o_parent_data     = out_data_q[Parent];
    assign o_parent_valid    = out_valid_q[Parent];
    assign o_misroute        = misroute_q;

    for (genvar i = 0; i < P; i++) begin : g_in
        noc_sync_fifo #(
            .DataWidth (DataWidth),
            .Depth     (FIFO_DEPTH)
        ) u_fifo (
            .clk_i        (i_sclk),
            .rst_i        (i_reset),
            .push_data_i  (in_data[i]),
            .push_valid_i (in_valid[i]),
            .push_ready_o (in_ready[i]),
            .pop_i        (pop[i]),
            .head_data_o  (head_data[i]),
            .head_valid_o (head_valid[i])
        );

        assign dest[i] = PW'(route_port(flit_addr(MaxFlitW'(head_data[i]), DataWidth, AddrWidth),
                                        CHILD_BASE, CHILD_SPAN, NUM_CHILD));
    end

    // Request matrix; a parent flit addressed back to the parent never requests.
    always_comb begin
        for (int unsigned o = 0; o < P; o++) begin
            for (int unsigned i = 0; i < P; i++) begin
                req[o][i] = head_valid[i] && (dest[i] == PW'(o)) &&
                            !((i == Parent) && (o == Parent));
            end
        end
    end

    // Round-robin arbitration and output-register next state. rr_q holds the first index to
    // search (last grant + 1), so it starts at 0 out of reset.
    always_comb begin
        logic        found;
        int unsigned idx;
        pop         = '0;
        load        = '0;
        misroute_d  = 1'b0;
        out_valid_d = out_valid_q;
        for (int unsigned o = 0; o < P; o++) begin
            gnt_idx[o]    = '0;
            rr_d[o]       = rr_q[o];
            out_data_d[o] = out_data_q[o];
            found         = 1'b0;
            for (int unsigned k = 0; k < P; k++) begin
                idx = 32'(rr_q[o]) + k;
                if (idx >= P) idx = idx - P;
                if (!found && req[o][idx]) begin
                    found      = 1'b1;
                    gnt_idx[o] = PW'(idx);
                end
            end
            if (found && (!out_valid_q[o] || out_ready[o])) begin
                load[o]          = 1'b1;
                pop[gnt_idx[o]]  = 1'b1;
                out_valid_d[o]   = 1'b1;
                out_data_d[o]    = head_data[gnt_idx[o]];
                rr_d[o]          = (gnt_idx[o] == PW'(P - 1)) ? '0 : gnt_idx[o] + 1'b1;
            end else if (out_ready[o]) begin
                out_valid_d[o]   = 1'b0;
            end
        end
        // Parent-sourced flit with no child owner: drop it and flag.
        if (head_valid[Parent] && (dest[Parent] == PW'(Parent))) begin
            pop[Parent] = 1'b1;
            misroute_d  = 1'b1;
        end
    end

    // Output registers, arbiter pointers and misroute pulse.
    always_ff @(posedge i_sclk) begin
        if (i_reset) begin
            for (int unsigned o = 0; o < P; o++) begin
                out_valid_q[o] <= 1'b0;
                out_data_q[o]  <= '0;
                rr_q[o]        <= '0;
            end
            misroute_q <= 1'b0;
        end else begin
            for (int unsigned o = 0; o < P; o++) begin
                out_valid_q[o] <= out_valid_d[o];
                out_data_q[o]  <= out_data_d[o];
                rr_q[o]        <= rr_d[o];
            end
            misroute_q <= misroute_d;
        end
    end

endmodule

// File: tb/tb_btree_router_node.sv
// Directed self-checking bench for btree_router_node (NUM_CHILD=2, CHILD_SPAN=1, depth 4).
module tb_btree_router_node;

    logic        clk = 1'b0;
    logic        rst;
    logic [71:0] ch_data;
    logic [1:0]  ch_valid, ch_ready_o, ch_valid_o, ch_ready_i;
    logic [71:0] ch_data_o;
    logic [35:0] par_data, par_data_o;
    logic        par_valid, par_ready_o, par_valid_o, par_ready_i, misroute;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    btree_router_node #(
        .DataWidth  (36),
        .AddrWidth  (4),
        .NUM_CHILD  (2),
        .CHILD_BASE (0),
        .CHILD_SPAN (1),
        .FIFO_DEPTH (4)
    ) dut (
        .i_sclk         (clk),
        .i_reset        (rst),
        .i_child_data   (ch_data),
        .i_child_valid  (ch_valid),
        .o_child_ready  (ch_ready_o),
        .o_child_data   (ch_data_o),
        .o_child_valid  (ch_valid_o),
        .i_child_ready  (ch_ready_i),
        .i_parent_data  (par_data),
        .i_parent_valid (par_valid),
        .o_parent_ready (par_ready_o),
        .o_parent_data  (par_data_o),
        .o_parent_valid (par_valid_o),
        .i_parent_ready (par_ready_i),
        .o_misroute     (misroute)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] mk(input logic [3:0] a, input logic [31:0] p);
        return {a, p};
    endfunction

    // Source 0/1 are children, source 2 is the parent.
    task automatic drive_src(input int s, input logic [35:0] d, input logic v);
        if (s == 2) begin
            par_data  = d;
            par_valid = v;
        end else begin
            ch_data[s*36 +: 36] = d;
            ch_valid[s]         = v;
        end
    endtask

    function automatic logic src_ready(input int s);
        return (s == 2) ? par_ready_o : ch_ready_o[s];
    endfunction

    task automatic idle_inputs();
        ch_valid  = 2'b00;
        par_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] seq [3];
        logic        fired [3];
        int          got, acc;

        // Reset held 3 cycles with every input valid.
        rst         = 1'b1;
        ch_data     = {mk(4'd1, 32'h11), mk(4'd0, 32'h22)};
        par_data    = mk(4'd0, 32'h33);
        ch_valid    = 2'b11;
        par_valid   = 1'b1;
        ch_ready_i  = 2'b11;
        par_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_ch_valid", ch_valid_o, 2'b00);
        check_eq("rst_par_valid", par_valid_o, 1'b0);
        check_eq("rst_ch_ready", ch_ready_o, 2'b00);
        check_eq("rst_par_ready", par_ready_o, 1'b0);
        check_eq("rst_misroute", misroute, 1'b0);
        check_eq("rst_ch_data", ch_data_o, 72'h0);
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", {par_ready_o, ch_ready_o}, 3'b111);

        // child0 -> addr 1 (child1): visible exactly two cycles after acceptance.
        drive_src(0, mk(4'd1, 32'hA1), 1'b1);
        @(negedge clk);
        idle_inputs();
        check_eq("lat_c1_n1", ch_valid_o, 2'b00);
        @(negedge clk);
        check_eq("lat_c1_valid", ch_valid_o, 2'b10);
        check_eq("lat_c1_data", ch_data_o[71:36], mk(4'd1, 32'hA1));
        @(negedge clk);
        check_eq("lat_c1_drained", ch_valid_o, 2'b00);

        // child0 -> addr 7 (outside 0..1) goes up to the parent.
        drive_src(0, mk(4'd7, 32'hB7), 1'b1);
        @(negedge clk);
        idle_inputs();
        check_eq("up_n1", par_valid_o, 1'b0);
        @(negedge clk);
        check_eq("up_valid", par_valid_o, 1'b1);
        check_eq("up_data", par_data_o, mk(4'd7, 32'hB7));
        check_eq("up_no_child", ch_valid_o, 2'b00);
        @(negedge clk);

        // Contention: three sources stream to child0; grants rotate 0,1,2,...
        for (int s = 0; s < 3; s++) begin
            seq[s]   = '0;
            fired[s] = 1'b0;
        end
        got = 0;
        for (int cyc = 0; cyc < 80 && got < 9; cyc++) begin
            if (ch_valid_o[0]) begin
                check_eq($sformatf("cont_%0d", got), ch_data_o[35:0],
                         {4'h0, 16'(got % 3), 16'(got / 3)});
                got++;
            end
            for (int s = 0; s < 3; s++) begin
                if (fired[s]) seq[s] = seq[s] + 16'd1;
                drive_src(s, mk(4'd0, {16'(s), seq[s]}), 1'b1);
                fired[s] = src_ready(s);
            end
            @(negedge clk);
        end
        check_eq("cont_count", got, 9);
        idle_inputs();
        repeat (30) @(negedge clk);
        check_eq("cont_idle", {par_valid_o, ch_valid_o}, 3'b000);

        // Backpressure: parent stalled, child0 streams upward; 4 FIFO + 1 output register.
        par_ready_i = 1'b0;
        acc = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            drive_src(0, mk(4'd7, 32'(acc)), 1'b1);
            if (ch_ready_o[0]) acc++;
            @(negedge clk);
        end
        check_eq("bp_accepted", acc, 5);
        check_eq("bp_ready_low", ch_ready_o[0], 1'b0);
        check_eq("bp_held_valid", par_valid_o, 1'b1);
        check_eq("bp_held_data", par_data_o, mk(4'd7, 32'd0));
        idle_inputs();
        par_ready_i = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (par_valid_o) begin
                check_eq($sformatf("bp_out_%0d", got), par_data_o, mk(4'd7, 32'(got)));
                got++;
            end
            @(negedge clk);
        end
        check_eq("bp_out_count", got, 5);

        // Misroute: parent flit addressed to 5 is dropped with a one-cycle pulse.
        drive_src(2, mk(4'd5, 32'hC5), 1'b1);
        @(negedge clk);
        idle_inputs();
        check_eq("mis_n1", misroute, 1'b0);
        @(negedge clk);
        check_eq("mis_pulse", misroute, 1'b1);
        check_eq("mis_no_out", {par_valid_o, ch_valid_o}, 3'b000);
        @(negedge clk);
        check_eq("mis_end", misroute, 1'b0);
        check_eq("mis_no_out2", {par_valid_o, ch_valid_o}, 3'b000);

        // Fill every FIFO toward a stalled child0, then reset mid-stream.
        ch_ready_i  = 2'b00;
        par_ready_i = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            for (int s = 0; s < 3; s++) drive_src(s, mk(4'd0, 32'(100 + s)), 1'b1);
            @(negedge clk);
        end
        check_eq("full_ready", {par_ready_o, ch_ready_o}, 3'b000);
        check_eq("full_c0_valid", ch_valid_o[0], 1'b1);
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst         = 1'b0;
        ch_ready_i  = 2'b11;
        par_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("mid_rst_idle", {par_valid_o, ch_valid_o}, 3'b000);
        check_eq("mid_rst_ready", {par_ready_o, ch_ready_o}, 3'b111);
        drive_src(0, mk(4'd1, 32'h1), 1'b1);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        check_eq("mid_rst_route", ch_valid_o, 2'b10);
        check_eq("mid_rst_data", ch_data_o[71:36], mk(4'd1, 32'h1));
        check_eq("mid_rst_par", par_valid_o, 1'b0);
        @(negedge clk);
        check_eq("mid_rst_done", {par_valid_o, ch_valid_o}, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
